mem_access_unit: RTL

- Initiator that drives the byte-addressed, little-endian, word-wide data memory on behalf of the datapath.
- Accepts one load/store request at a time over a valid/ready handshake.
- Issues word-aligned memory accesses: sub-word stores use read-modify-write, and loads return extracted, sign- or zero-extended data.
- Flags misaligned, out-of-range and illegal requests without touching memory.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_lane_mux.sv | 31 +++
 rtl/mem_access_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: op codes, size codes and FSM encoding shared by the memory access unit
package mem_pkg;
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WRITE, ST_RESP} state_t;
    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus the word-wide memory bus
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write
    );
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: little-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_mux
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_uns;
    logic [1:0]  w_size;
    assign w_uns  = i_op[2];
    assign w_size = i_op[1:0];
    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];
    // Load result: pick the addressed lane(s) and sign- or zero-extend
    always_comb begin
        o_load = w_size == SZ_B ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                 w_size == SZ_H ? {{16{~w_uns & w_half[15]}}, w_half} : i_rdata;
    end
    // Store merge: overwrite only the target lane(s) of the word read back from memory
    always_comb begin
        o_merge = i_rdata;
        if (w_size == SZ_B) o_merge[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
        else if (w_size == SZ_H) o_merge[{i_addr[1], 4'b0000} +: 16] = i_wdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator driving the byte-addressed word-wide data memory
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_bad;
    assign w_misaligned   = (bus.req_op[1:0] == SZ_H && bus.req_addr[0]) ||
                            (bus.req_op[1:0] == SZ_W && bus.req_addr[1:0] != 2'b00);
    assign w_out_of_range = (bus.req_addr >> MEM_ADDR_BITS) != 32'd0;
    assign w_bad          = w_misaligned || w_out_of_range || !op_legal(bus.req_op);
    mem_lane_mux u_lane (
        .i_addr  (r_addr_lo),
        .i_op    (r_op[2:0]),
        .i_rdata (bus.mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );
    // Strobes come from state alone so reset kills a write in the cycle it is asserted
    assign bus.req_ready  = r_state == ST_IDLE;
    assign bus.resp_valid = r_state == ST_RESP;
    assign bus.mem_write  = r_state == ST_WRITE || (r_state == ST_ACCESS && r_op == OP_SW);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    // Request sequencing: accept/check, memory access, optional merge write, one-cycle response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LB;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 16'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.req_valid) begin
                    r_op      <= bus.req_op;
                    r_addr_lo <= bus.req_addr[1:0];
                    r_wdata   <= bus.req_wdata[15:0];
                    if (w_bad) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_wdata <= bus.req_wdata;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_op[3]) begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_op[1:0] == SZ_W) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_mem_wdata <= w_merge;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                    r_state <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
